// File: rtl/rpn_pkg.sv
// Operator encoding, error codes, FSM states and precedence shared by the
// infix-to-postfix converter and its operator stack.
package rpn_pkg;

  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NUL = 3'b000;
  localparam op_t OP_MUL = 3'b001;
  localparam op_t OP_ADD = 3'b010;
  localparam op_t OP_SUB = 3'b011;
  localparam op_t OP_EQ  = 3'b100;
  localparam op_t OP_LP  = 3'b101;
  localparam op_t OP_RP  = 3'b110;
  localparam op_t OP_DIV = 3'b111;

  typedef logic [1:0] err_t;
  localparam err_t ERR_NONE = 2'b00;
  localparam err_t ERR_OVF  = 2'b01;
  localparam err_t ERR_RPAR = 2'b10;
  localparam err_t ERR_LPAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, EMIT_IN, CMP, EMIT_TOP, PUSH, FLUSH, EMIT_EQ, ERROR
  } state_e;

  // What is draining the stack: a binary operator, a ')' or an '='.
  typedef enum logic [1:0] {MODE_BIN, MODE_RPAR, MODE_FLUSH} mode_e;

  function automatic logic [1:0] prec(input op_t op);
    case (op)
      OP_MUL, OP_DIV:         prec = 2'd2;
      OP_NUL, OP_ADD, OP_SUB: prec = 2'd1;
      default:                prec = 2'd0;
    endcase
  endfunction

  function automatic op_t norm_op(input op_t op);
    return (op == OP_NUL) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/rpn_op_stack.sv
// LIFO of operator codes with a combinational top-of-stack view.
// Push into a full stack and pop from an empty one are ignored; clear wins.
module rpn_op_stack #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    top_idx;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign top_idx = count_q - CW'(1);
  assign top_o   = empty_o ? '0 : mem_q[top_idx[AW-1:0]];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (push_i && !full_o)
      count_d = count_q + CW'(1);
    else if (pop_i && !empty_o)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // Storage needs no reset: entries above count_q are never observed.
  always_ff @(posedge CLK) begin
    if (push_i && !full_o && !clr_i)
      mem_q[count_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/shunting_yard.sv
// Streaming infix-to-postfix converter: operands pass straight through,
// operators are reordered through a precedence stack with sticky error reporting.
module shunting_yard
  import rpn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_is_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_op,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [LW-1:0]     level
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_is_op_q, out_is_op_d;
  logic              err_q, err_d;
  err_t              err_code_q, err_code_d;

  logic              stk_push, stk_pop, stk_clr;
  op_t               stk_top;
  logic              stk_full, stk_empty;
  logic [LW-1:0]     stk_count;

  logic              accept, out_hs, pop_ok;
  op_t               in_op;

  rpn_op_stack #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_stack (
    .CLK        (CLK),
    .RST        (RST),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .clr_i      (stk_clr),
    .push_dat_i (op_q),
    .top_o      (stk_top),
    .count_o    (stk_count),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  assign accept = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign in_op  = norm_op(in_data[OP_W-1:0]);

  // Whether the current top must be popped and emitted before moving on.
  always_comb begin
    pop_ok = !stk_empty && (stk_top != OP_LP);
    if (mode_q == MODE_BIN)
      pop_ok = pop_ok && (prec(stk_top) >= prec(op_q));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    op_d        = op_q;
    out_data_d  = out_data_q;
    out_is_op_d = out_is_op_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_is_op) begin
            out_data_d  = in_data;
            out_is_op_d = 1'b0;
            state_d     = EMIT_IN;
          end else begin
            op_d = in_op;
            case (in_op)
              OP_LP:   state_d = PUSH;
              OP_RP: begin
                mode_d  = MODE_RPAR;
                state_d = CMP;
              end
              OP_EQ: begin
                mode_d  = MODE_FLUSH;
                state_d = FLUSH;
              end
              default: begin
                mode_d  = MODE_BIN;
                state_d = CMP;
              end
            endcase
          end
        end
      end

      EMIT_IN: if (out_hs) state_d = IDLE;

      CMP: begin
        if (pop_ok) begin
          stk_pop     = 1'b1;
          out_data_d  = DATA_W'(stk_top);
          out_is_op_d = 1'b1;
          state_d     = EMIT_TOP;
        end else if (mode_q == MODE_RPAR) begin
          if (stk_empty) begin
            err_d      = 1'b1;
            err_code_d = ERR_RPAR;
            state_d    = ERROR;
          end else begin
            stk_pop = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = PUSH;
        end
      end

      // Pop the next qualifying entry on the handshake itself so
      // back-to-back pops leave no idle cycle on the output.
      EMIT_TOP: begin
        if (out_hs) begin
          if (pop_ok) begin
            stk_pop     = 1'b1;
            out_data_d  = DATA_W'(stk_top);
            out_is_op_d = 1'b1;
          end else begin
            state_d = (mode_q == MODE_FLUSH) ? FLUSH : CMP;
          end
        end
      end

      FLUSH: begin
        if (pop_ok) begin
          stk_pop     = 1'b1;
          out_data_d  = DATA_W'(stk_top);
          out_is_op_d = 1'b1;
          state_d     = EMIT_TOP;
        end else if (stk_empty) begin
          out_data_d  = DATA_W'(OP_EQ);
          out_is_op_d = 1'b1;
          state_d     = EMIT_EQ;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_LPAR;
          state_d    = ERROR;
        end
      end

      EMIT_EQ: if (out_hs) state_d = IDLE;

      PUSH: begin
        if (stk_full) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
          state_d    = ERROR;
        end else begin
          stk_push = 1'b1;
          state_d  = IDLE;
        end
      end

      ERROR: begin
        if (accept && in_is_op && (in_op == OP_EQ)) begin
          stk_clr    = 1'b1;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q      <= MODE_BIN;
      op_q        <= OP_NUL;
      out_data_q  <= '0;
      out_is_op_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mode_q      <= mode_d;
      op_q        <= op_d;
      out_data_q  <= out_data_d;
      out_is_op_q <= out_is_op_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == ERROR);
    out_valid = (state_q == EMIT_IN) || (state_q == EMIT_TOP) || (state_q == EMIT_EQ);
    out_data  = out_data_q;
    out_is_op = out_is_op_q;
    err       = err_q;
    err_code  = err_code_q;
    level     = stk_count;
  end

endmodule

// File: tb/tb_shunting_yard.sv
// Scoreboard bench for shunting_yard: expected postfix tokens are queued as each
// expression is driven and compared as the DUT emits them.
module tb_shunting_yard;
  import rpn_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_is_op = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_is_op;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  level;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  bit          stall_mode = 1'b0;
  bit          mon_en = 1'b1;
  int          stall_cnt = 0;

  shunting_yard #(.DATA_W(32), .DEPTH(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_is_op  (in_is_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_is_op (out_is_op),
    .err       (err),
    .err_code  (err_code),
    .level     (level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] tok(input byte c);
    logic [7:0] d;
    d = c - 8'd48;
    case (c)
      "*":     tok = {1'b1, 29'd0, OP_MUL};
      "/":     tok = {1'b1, 29'd0, OP_DIV};
      "+":     tok = {1'b1, 29'd0, OP_ADD};
      "-":     tok = {1'b1, 29'd0, OP_SUB};
      "=":     tok = {1'b1, 29'd0, OP_EQ};
      "(":     tok = {1'b1, 29'd0, OP_LP};
      ")":     tok = {1'b1, 29'd0, OP_RP};
      default: tok = {1'b0, 24'd0, d};
    endcase
  endfunction

  task automatic send(input logic op, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_is_op = op;
    in_data  = d;
    forever begin
      #1;
      if (in_ready) begin
        @(posedge CLK);
        break;
      end
      n++;
      if (n > 300) begin
        check("send_timeout", in_ready, 1'b1);
        break;
      end
      @(negedge CLK);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input string src, input string exp);
    logic [32:0] t;
    for (int i = 0; i < exp.len(); i++) exp_q.push_back(tok(exp[i]));
    for (int i = 0; i < src.len(); i++) begin
      t = tok(src[i]);
      send(t[32], t[31:0]);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
      @(negedge CLK);
      #3;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_err(input string tag, input logic v);
    int n;
    n = 0;
    while (err !== v && n < 100) begin
      @(negedge CLK);
      #3;
      n++;
    end
    check(tag, err, v);
  endtask

  // Output monitor: optionally stalls each token 5 cycles, re-checking it while held.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        out_ready = 1'b1;
        stall_cnt = 0;
      end else begin
        out_ready = !(stall_mode && out_valid && stall_cnt < 5);
        if (!out_ready) stall_cnt++;
        #1;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
          end else begin
            check("token", {out_is_op, out_data}, exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              stall_cnt = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid2", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_is_op", out_is_op, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    check("rst_level", level, 2'd0);

    run("3+4*2=", "342*+=");
    drain("drain_prec");
    check("prec_err", err, 1'b0);
    check("prec_level", level, 2'd0);

    run("(1+2)*3=", "12+3*=");
    drain("drain_paren");
    run("5-3-1=", "53-1-=");
    drain("drain_left_assoc");
    run("8/4*2=", "84/2*=");
    drain("drain_muldiv");

    // Code 000 acts as '+'; high bits of an operator word are ignored.
    exp_q.push_back(tok("1"));
    exp_q.push_back(tok("2"));
    exp_q.push_back(tok("9"));
    exp_q.push_back(tok("*"));
    exp_q.push_back(tok("+"));
    exp_q.push_back(tok("="));
    send(1'b0, 32'd1);
    send(1'b1, 32'd0);
    send(1'b0, 32'd2);
    send(1'b1, 32'hFFFF_FFF9);
    send(1'b0, 32'd9);
    send(1'b1, {29'd0, OP_EQ});
    drain("drain_code0");

    run("(((", "");
    wait_err("ovf_err", 1'b1);
    check("ovf_code", err_code, 2'b01);
    check("ovf_level", level, 2'd2);
    check("ovf_in_ready", in_ready, 1'b1);
    run("7=", "");
    wait_err("ovf_clear", 1'b0);
    check("ovf_clear_level", level, 2'd0);
    check("ovf_clear_code", err_code, 2'b00);

    run(")", "");
    wait_err("rpar_err", 1'b1);
    check("rpar_code", err_code, 2'b10);
    run("=", "");
    wait_err("rpar_clear", 1'b0);

    run("(1=", "1");
    wait_err("lpar_err", 1'b1);
    check("lpar_code", err_code, 2'b11);
    check("lpar_empty_q", exp_q.size(), 0);
    run("=", "");
    wait_err("lpar_clear", 1'b0);
    check("lpar_level", level, 2'd0);

    stall_mode = 1'b1;
    run("6/2=", "62/=");
    drain("drain_stall");
    stall_mode = 1'b0;

    // Reset while the flush of 1+2*3= is holding '*' on the output.
    stall_mode = 1'b1;
    run("1+2*3=", "123*");
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      #2;
      if (out_valid && out_is_op) break;
    end
    check("flush_star", {out_valid, out_is_op, out_data}, {2'b11, 29'd0, OP_MUL});
    mon_en = 1'b0;
    exp_q.delete();
    RST = 1'b1;
    #1;
    check("midrst_out_valid_async", out_valid, 1'b0);
    @(negedge CLK);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_level", level, 2'd0);
    RST = 1'b0;
    stall_mode = 1'b0;
    @(negedge CLK);
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    mon_en = 1'b1;
    run("9=", "9=");
    drain("drain_after_rst");
    check("final_level", level, 2'd0);
    check("final_err", err, 1'b0);

    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shunting_yard.md
SHUNTING_YARD -- requirements
Module: shunting_yard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/token width, minimum 3.
REQ-002 SHALL have parameter DEPTH, default 16: operator stack entries, minimum 2.
REQ-003 SHALL have port CLK, input, 1, clock, rising edge; reset RST is asynchronous, active-high.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input token present.
REQ-006 SHALL have port in_ready, output, 1, token accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, DATA_W, operand value, or operator code in [2:0].
REQ-008 SHALL have port in_is_op, input, 1, in_data is an operator.
REQ-009 SHALL have port out_valid, output, 1, postfix token present.
REQ-010 SHALL have port out_ready, input, 1, token consumed when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, DATA_W, postfix token; operators zero-extended.
REQ-012 SHALL have port out_is_op, output, 1, out_data is an operator.
REQ-013 SHALL have port err, output, 1, sticky expression error.
REQ-014 SHALL have port err_code, output, 2: 01 stack overflow, 10 unmatched ')', 11 unmatched '('.
REQ-015 SHALL have port level, output, $clog2(DEPTH+1), current stack occupancy.

Function
REQ-016 Operator codes SHALL be: 001 '*', 111 '/', 010 '+', 011 '-', 100 '=', 101 '(', 110 ')'. Code 000 SHALL be treated as '+'.
REQ-017 Precedence SHALL be: '*' and '/' = 2; '+' and '-' = 1. All operators SHALL be left-associative.
REQ-018 FSM states SHALL be IDLE, EMIT_IN, CMP, EMIT_TOP, PUSH, FLUSH, EMIT_EQ, ERROR.
REQ-019 in_ready SHALL be 1 only in IDLE and ERROR.
REQ-020 Operand accepted in cycle N: out_valid=1 in cycle N+1 with out_is_op=0, via EMIT_IN.
REQ-021 Binary operator accepted: CMP SHALL pop and emit the top (EMIT_TOP, then CMP again) while the stack is non-empty, the top is not '(', and prec(top) >= prec(input). It SHALL then go to PUSH.
REQ-022 '(' SHALL go directly to PUSH.
REQ-023 ')' SHALL pop and emit until the top is '('. It SHALL pop the '(' without emitting it, and emit nothing for ')'.
REQ-024 ')' reaching an empty stack SHALL go to ERROR with err_code 10.
REQ-025 '=' SHALL go to FLUSH: pop and emit every entry, then EMIT_EQ emits '=', then IDLE.
REQ-026 '(' found during FLUSH SHALL go to ERROR with err_code 11.
REQ-027 PUSH with level==DEPTH SHALL go to ERROR with err_code 01 and leave the stack unchanged.
REQ-028 Backpressure: out_data/out_is_op/out_valid SHALL hold stable while out_valid && !out_ready. No pop SHALL occur until the current token is consumed.
REQ-029 Each emit state SHALL advance only on out_valid && out_ready. Zero-bubble pops: next token valid the cycle after the handshake.
REQ-030 ERROR SHALL accept and discard tokens with out_valid=0 until '=' is accepted. It SHALL then clear the stack, clear err, and return to IDLE.
REQ-031 Simultaneous push and pop SHALL never be issued by the FSM. level SHALL update the cycle after each push/pop.

Reset
REQ-032 RST SHALL force IDLE, stack empty, level=0, out_valid=0, out_data=0, out_is_op=0, err=0, err_code=00, in_ready=1 after release.
REQ-033 RST mid-expression or mid-emit SHALL discard all state. No token SHALL be emitted afterward from the prior expression.

Structure
REQ-034 Package rpn_pkg SHALL hold operator code constants, err_code constants, the FSM state enum, and a precedence function.
REQ-035 The stack SHALL be a sub-module rpn_op_stack (WIDTH=3, DEPTH), with: synchronous push/pop strobes, combinational top, count, full, empty, and async RST.

Verification
REQ-036 Input 3 + 4 * 2 = with out_ready=1 -> out 3,4,2,*,+,= ; err=0 ; level=0 at end.
REQ-037 Input ( 1 + 2 ) * 3 = -> out 1,2,+,3,*,= ; 5 - 3 - 1 = -> 5,3,-,1,-,= .
REQ-038 DEPTH=2, input ( ( ( -> err=1, err_code=01. Then 7 = -> nothing emitted, err=0 after '='.
REQ-039 Input ) -> err_code=10. Input ( 1 = -> out 1, then err_code=11.
REQ-040 Input 6 / 2 = with out_ready low for 5 cycles on each token -> out_data held stable; sequence 6,2,/,= intact.
REQ-041 RST asserted during a FLUSH of 1 + 2 * 3 = -> out_valid=0 next cycle, level=0. Then 9 = -> out 9,= .
